lfsr_arbiter: RTL and testbench
===============================

// Module: lfsr_arbiter
// PURPOSE
//  Shares one resource between REQ requesters using a randomised-priority arbiter.
//  An internal maximal-length LFSR supplies the starting point of each priority scan,
//  so no requester is statically favoured. A hold timeout preempts long owners.
//  Sits in front of shared datapath resources; seed is loadable for reproducible runs.
// PARAMETERS
//  REQ      4   number of requesters; power of 2, 2..16
//  LFSR_W   8   LFSR width, 3..16, must be >= IDX_W (IDX_W = $clog2(REQ))
//  SEED     1   LFSR reset value; 0 is illegal and is forced to 1
//  MAX_HOLD 8   max cycles one owner holds grant while others wait; 0 = never preempt
// PORTS
//  clk        in   1       clock, all flops on posedge
//  reset      in   1       asynchronous, active-high
//  req        in   REQ     level request; owner keeps its bit high while using resource
//  seed_we    in   1       load seed_in into LFSR this cycle
//  seed_in    in   LFSR_W  new seed (0 loads as 1)
//  grant      out  REQ     one-hot grant, registered
//  grant_id   out  IDX_W   binary index of owner; valid only while busy=1
//  busy       out  1       resource owned (== |grant)
//  preempt    out  1       1-cycle pulse on the cycle grant was dropped by timeout
//  lfsr_q     out  LFSR_W  current LFSR state (debug/verification)
// BEHAVIOUR
//  Reset: grant=0, grant_id=0, busy=0, preempt=0, lfsr_q=SEED (1 if SEED==0),
//   hold_cnt=0, mask_vld=0, state=IDLE. Asserting reset mid-grant clears all at once.
//  LFSR: shift left, bit0 = XOR of taps from table (3:2,1 4:3,2 5:4,2 6:5,4 7:6,5
//   8:7,5,4,3 9:8,4 10:9,6 11:10,8 12:11,5,3,0 13:12,3,2,0 14:13,4,2,0 15:14,13
//   16:15,14,12,3). Steps ONLY on a cycle an arbitration decision is made.
//  Pick: start = lfsr_q[IDX_W-1:0] (value before the step); scan idx start,start+1,..
//   mod REQ; first eligible req wins. Eligible = req & ~mask, where mask = one-hot of
//   last preempted owner while mask_vld=1; if masked set is empty, use plain req.
//  FSM IDLE: grant=0. If |req: next edge -> BUSY, grant=pick, grant_id, step LFSR,
//   hold_cnt=0, mask_vld=0. Latency req->grant = 1 cycle.
//  FSM BUSY: hold_cnt increments (saturating) each cycle.
//   - req[owner]==0 -> next edge IDLE, grant=0 (release; no preempt pulse).
//   - else MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 && |(req & ~grant) -> next edge IDLE,
//     grant=0, preempt=1, mask=owner, mask_vld=1.
//   - else stay; grant stable. Lone requester is never preempted.
//  Grant-to-grant gap is always >=1 idle cycle (grant=0 in IDLE).
//  seed_we: takes priority over stepping in the same cycle; decision that cycle
//   still uses old lfsr_q. Loading 0 yields 1. Seed load never alters grant.
//  hold_cnt width $clog2(MAX_HOLD+1) (min 1); no wrap (saturates).
//  Illegal params (REQ not pow2/out of range, LFSR_W out of range or < IDX_W):
//   $error + $fatal in an initial block.
// STRUCTURE
//  Package lfsr_arb_pkg: state enum {IDLE,BUSY}, function lfsr_taps(width) returning
//   tap mask per table above, constants LFSR_W_MIN=3, LFSR_W_MAX=16.
//  Sub-module lfsr_arb_pick: combinational rotate-priority encoder
//   (req, mask, mask_vld, start) -> one-hot grant + index + any.
//  Top holds LFSR, FSM, hold counter, mask register; all flops async reset.
// TESTING (REQ=4, LFSR_W=8, SEED=1, MAX_HOLD=8; LFSR sequence 01,02,04,08,11,..)
//  1 Reset, req=1111 held -> grant=0010 one cycle later (start=1), lfsr_q=02.
//  2 Owner drops req -> grant=0 next cycle, then grant=0100 (start=2), preempt=0.
//  3 req=0001 held alone 20 cycles -> grant=0001 stays, preempt never asserted.
//  4 req=0011 held, owner 0 -> after 8 busy cycles grant=0, preempt=1 one cycle,
//    next grant=0010 (owner 0 masked) regardless of LFSR start.
//  5 seed_we=1, seed_in=00 in same cycle as IDLE decision -> decision uses old start,
//    lfsr_q=01 afterwards (not stepped value).
//  6 reset asserted mid-BUSY, between clock edges -> grant/busy drop asynchronously;
//    after release, req=1000 -> grant=1000 next cycle, lfsr_q restarts at 01->02.

Source files
------------

// File: rtl/lfsr_arb_pkg.sv
// Shared types, limits and LFSR tap table for the randomised-priority arbiter.
package lfsr_arb_pkg;

    localparam int unsigned LFSR_W_MIN = 3;
    localparam int unsigned LFSR_W_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Maximal-length feedback taps for a shift-left LFSR; bit n set means q[n] feeds bit0.
    function automatic logic [LFSR_W_MAX-1:0] lfsr_taps(input int unsigned width);
        logic [LFSR_W_MAX-1:0] taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_arb_pick.sv
// Rotating-priority encoder: scans from a start index and returns the first eligible requester.
module lfsr_arb_pick
    import lfsr_arb_pkg::*;
#(
    parameter int unsigned REQ   = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [REQ-1:0]   req,
    input  logic [REQ-1:0]   mask,
    input  logic             mask_vld,
    input  logic [IDX_W-1:0] start,
    output logic [REQ-1:0]   grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic [REQ-1:0]   masked;
    logic [REQ-1:0]   elig;
    logic [IDX_W-1:0] cand;

    // Skip the last preempted owner, unless that would leave nobody to serve.
    always_comb begin
        masked = req & ~mask;
        elig   = (mask_vld && (|masked)) ? masked : req;
    end

    // REQ is a power of two, so index arithmetic wraps modulo REQ for free.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < REQ; off++) begin
            cand = start + IDX_W'(off);
            if (!any_c && elig[cand]) begin
                any_c         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/lfsr_arbiter.sv
// Randomised-priority arbiter with hold-timeout preemption; LFSR picks each scan start.
module lfsr_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter  int unsigned REQ      = 4,
    parameter  int unsigned LFSR_W   = 8,
    parameter  int unsigned SEED     = 1,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W    = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ-1:0]    req,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [REQ-1:0]    grant,
    output logic [IDX_W-1:0]  grant_id,
    output logic              busy,
    output logic              preempt,
    output logic [LFSR_W-1:0] lfsr_q
);

    localparam int unsigned       HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [LFSR_W-1:0] SEED_RAW   = LFSR_W'(SEED);
    localparam logic [LFSR_W-1:0] SEED_EFF   = (SEED_RAW == '0) ? LFSR_W'(1) : SEED_RAW;
    localparam logic [LFSR_W-1:0] TAPS       = LFSR_W'(lfsr_taps(LFSR_W));
    localparam bit PARAMS_OK = (REQ >= 2) && (REQ <= 16) && ((REQ & (REQ - 1)) == 0) &&
                               (LFSR_W >= LFSR_W_MIN) && (LFSR_W <= LFSR_W_MAX) &&
                               (LFSR_W >= IDX_W);

    // Refuse to elaborate an unsupported configuration.
    if (!PARAMS_OK) begin : g_bad_params
        initial begin
            $error("lfsr_arbiter: illegal parameters REQ=%0d LFSR_W=%0d", REQ, LFSR_W);
            $fatal(1, "lfsr_arbiter: aborting on illegal parameters");
        end
    end

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REQ-1:0]    mask_q, mask_d;
    logic              mask_vld_q, mask_vld_d;
    logic [REQ-1:0]    grant_d;
    logic [IDX_W-1:0]  grant_id_d;
    logic              busy_d;
    logic              preempt_d;
    logic [LFSR_W-1:0] lfsr_d;
    logic              step;

    logic [REQ-1:0]    pick_grant_c;
    logic [IDX_W-1:0]  pick_idx_c;
    logic              pick_any_c;
    logic              owner_req_c;
    logic              others_wait_c;

    lfsr_arb_pick #(
        .REQ   (REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .mask     (mask_q),
        .mask_vld (mask_vld_q),
        .start    (lfsr_q[IDX_W-1:0]),
        .grant_c  (pick_grant_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );

    assign owner_req_c   = |(req & grant);
    assign others_wait_c = |(req & ~grant);

    // Next-state, grant, hold counter and mask decisions.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        grant_id_d = grant_id;
        preempt_d  = 1'b0;
        hold_d     = hold_q;
        mask_d     = mask_q;
        mask_vld_d = mask_vld_q;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_any_c) begin
                    state_d    = BUSY;
                    grant_d    = pick_grant_c;
                    grant_id_d = pick_idx_c;
                    hold_d     = '0;
                    mask_vld_d = 1'b0;
                    step       = 1'b1;
                end
            end
            BUSY: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (!owner_req_c) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && others_wait_c) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    preempt_d  = 1'b1;
                    mask_d     = grant;
                    mask_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    // Seed load wins over the decision step; the decision itself used the old value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_we) begin
            lfsr_d = (seed_in == '0) ? LFSR_W'(1) : seed_in;
        end else if (step) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            mask_q     <= '0;
            mask_vld_q <= 1'b0;
            grant      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            preempt    <= 1'b0;
            lfsr_q     <= SEED_EFF;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            mask_q     <= mask_d;
            mask_vld_q <= mask_vld_d;
            grant      <= grant_d;
            grant_id   <= grant_id_d;
            busy       <= busy_d;
            preempt    <= preempt_d;
            lfsr_q     <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: vector table, directed corner cases, random vs model.
module tb_lfsr_arbiter;

    localparam int unsigned REQ      = 4;
    localparam int unsigned LFSR_W   = 8;
    localparam int unsigned SEED     = 1;
    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       seed_we;
    logic [7:0] seed_in;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       preempt;
    logic [7:0] lfsr_q;

    int checks = 0;
    int errors = 0;

    // Reference model state (owner as an integer, busy time counted from 1).
    bit m_busy;
    int m_owner;
    int m_cycles;
    bit m_mvld;
    int m_midx;
    bit m_pre;
    int m_lfsr;

    typedef struct {
        logic [3:0] req;
        logic       swe;
        logic [7:0] sin;
        logic [3:0] g;
        logic [1:0] id;
        logic       pre;
        logic [7:0] lf;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    lfsr_arbiter #(
        .REQ      (REQ),
        .LFSR_W   (LFSR_W),
        .SEED     (SEED),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .seed_we  (seed_we),
        .seed_in  (seed_in),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt),
        .lfsr_q   (lfsr_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lfsr_next(input int v);
        int fb;
        fb = $countones(v & 'hB8) % 2;
        return ((v << 1) & 'hFF) | fb;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = '0;
        seed_we = 1'b0;
        seed_in = '0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        chk("rst_lfsr", 32'(lfsr_q), 32'h01);
        reset    = 1'b0;
        m_busy   = 1'b0;
        m_owner  = 0;
        m_cycles = 0;
        m_mvld   = 1'b0;
        m_midx   = 0;
        m_pre    = 1'b0;
        m_lfsr   = 1;
    endtask

    // One clock of the arbiter rules, applied to the model.
    task automatic model_clock(input logic [3:0] r, input bit swe, input int sin);
        int         start;
        logic [3:0] elig;
        logic [3:0] others;
        bit         decided;
        int         idx;
        start   = m_lfsr % REQ;
        decided = 1'b0;
        m_pre   = 1'b0;
        if (!m_busy) begin
            if (r != 0) begin
                elig = r;
                if (m_mvld && ((r & ~(4'b1 << m_midx)) != 0)) elig = r & ~(4'b1 << m_midx);
                for (int k = 0; k < REQ; k++) begin
                    idx = (start + k) % REQ;
                    if (!decided && elig[idx]) begin
                        decided = 1'b1;
                        m_owner = idx;
                    end
                end
                m_busy   = 1'b1;
                m_cycles = 1;
                m_mvld   = 1'b0;
            end
        end else begin
            others = r & ~(4'b1 << m_owner);
            if (!r[m_owner]) begin
                m_busy = 1'b0;
            end else if (MAX_HOLD != 0 && m_cycles == MAX_HOLD && others != 0) begin
                m_busy = 1'b0;
                m_pre  = 1'b1;
                m_mvld = 1'b1;
                m_midx = m_owner;
            end else begin
                m_cycles++;
            end
        end
        if (swe) m_lfsr = (sin == 0) ? 1 : sin;
        else if (decided) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic check_model();
        chk("rnd_grant", 32'(grant), m_busy ? (32'h1 << m_owner) : 32'h0);
        chk("rnd_busy", 32'(busy), 32'(m_busy));
        chk("rnd_preempt", 32'(preempt), 32'(m_pre));
        chk("rnd_lfsr", 32'(lfsr_q), 32'(m_lfsr));
        if (m_busy) chk("rnd_id", 32'(grant_id), 32'(m_owner));
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        seed_we = 1'b0;
        seed_in = '0;

        // Cycle-by-cycle vectors from reset: first grant, release, seed-load corner cases.
        vecs[0]  = '{4'b1111, 1'b0, 8'h00, 4'b0010, 2'd1, 1'b0, 8'h02};
        vecs[1]  = '{4'b1101, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h02};
        vecs[2]  = '{4'b1101, 1'b0, 8'h00, 4'b0100, 2'd2, 1'b0, 8'h04};
        vecs[3]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h04};
        vecs[4]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h04};
        vecs[5]  = '{4'b1111, 1'b1, 8'h00, 4'b0001, 2'd0, 1'b0, 8'h01};
        vecs[6]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h01};
        vecs[7]  = '{4'b0000, 1'b1, 8'h08, 4'b0000, 2'd0, 1'b0, 8'h08};
        vecs[8]  = '{4'b1000, 1'b0, 8'h00, 4'b1000, 2'd3, 1'b0, 8'h11};
        vecs[9]  = '{4'b1000, 1'b1, 8'h33, 4'b1000, 2'd3, 1'b0, 8'h33};
        vecs[10] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h33};
        vecs[11] = '{4'b0110, 1'b0, 8'h00, 4'b0010, 2'd1, 1'b0, 8'h66};
        vecs[12] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 8'h66};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req     = vecs[i].req;
            seed_we = vecs[i].swe;
            seed_in = vecs[i].sin;
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|vecs[i].g));
            chk($sformatf("vec%0d_preempt", i), 32'(preempt), 32'(vecs[i].pre));
            chk($sformatf("vec%0d_lfsr", i), 32'(lfsr_q), 32'(vecs[i].lf));
            if (|vecs[i].g) chk($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].id));
        end
        seed_we = 1'b0;

        // Lone requester is never preempted.
        do_reset();
        req = 4'b0001;
        tick();
        chk("lone_first", 32'(grant), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lone_grant", 32'(grant), 32'h1);
            chk("lone_preempt", 32'(preempt), 32'h0);
        end

        // Timeout preemption with the previous owner masked on the next pick.
        do_reset();
        seed_we = 1'b1;
        seed_in = 8'h04;
        tick();
        seed_we = 1'b0;
        chk("pre_seed", 32'(lfsr_q), 32'h04);
        req = 4'b0011;
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick();
            chk("pre_hold0", 32'(grant), 32'h1);
            chk("pre_nopulse0", 32'(preempt), 32'h0);
        end
        tick();
        chk("pre_drop0", 32'(grant), 32'h0);
        chk("pre_pulse0", 32'(preempt), 32'h1);
        tick();
        chk("pre_next", 32'(grant), 32'h2);
        chk("pre_pulse_end", 32'(preempt), 32'h0);
        chk("pre_lfsr", 32'(lfsr_q), 32'h11);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            chk("pre_hold1", 32'(grant), 32'h2);
        end
        tick();
        chk("pre_drop1", 32'(grant), 32'h0);
        chk("pre_pulse1", 32'(preempt), 32'h1);
        tick();
        chk("pre_back", 32'(grant), 32'h1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b1111;
        tick();
        chk("ar_grant", 32'(grant), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_grant_drop", 32'(grant), 32'h0);
        chk("ar_busy_drop", 32'(busy), 32'h0);
        chk("ar_lfsr", 32'(lfsr_q), 32'h01);
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1000;
        tick();
        chk("ar_after", 32'(grant), 32'h8);
        chk("ar_after_id", 32'(grant_id), 32'h3);
        chk("ar_after_lfsr", 32'(lfsr_q), 32'h02);

        // Randomised traffic against the reference model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] r;
            bit         swe;
            int         sin;
            r = 4'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            swe = ($urandom_range(0, 15) == 0);
            sin = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            req     = r;
            seed_we = swe;
            seed_in = 8'(sin);
            model_clock(r, swe, sin);
            tick();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
